// File: rtl/gb_host_arb_pkg.sv
// ============================================================================
//  Module      : gb_host_arb_pkg
//  Description : Shared types and constants for the two-requester ghostbus
//                host arbiter (FSM state encoding, wait-counter width,
//                requester indices).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gb_host_arb_pkg;

    // Arbiter FSM states, fixed encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Width of the read-latency wait counter (latencies 1..15)
    localparam int unsigned c_LAT_CNT_W = 4;

    // Requester indices into the one-hot grant vector
    localparam int unsigned c_REQ0 = 0;
    localparam int unsigned c_REQ1 = 1;

endpackage

`default_nettype wire

// File: rtl/gb_host_arb_rr_arb2.sv
// ============================================================================
//  Module      : gb_rr_arb2
//  Description : Two-input grant logic for gb_host_arb. Produces a one-hot
//                grant from the two request valids and the "last granted"
//                pointer. Build option GB_ARB_FIXED_PRIO_EN switches to a
//                fixed priority where requester 0 always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_rr_arb2
    import gb_host_arb_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last,
    output logic [1:0] o_grant
);

`ifdef GB_ARB_FIXED_PRIO_EN
    // The pointer has no meaning with a fixed priority
    logic w_unused_last;
    assign w_unused_last = i_last;

    // Requester 0 always wins contention
    always_comb begin
        o_grant = 2'b00;
        if (i_valid0) begin
            o_grant[c_REQ0] = 1'b1;
        end else if (i_valid1) begin
            o_grant[c_REQ1] = 1'b1;
        end
    end
`else
    // Round-robin: on contention the requester that did not go last wins
    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            if (i_last) begin
                o_grant[c_REQ0] = 1'b1;
            end else begin
                o_grant[c_REQ1] = 1'b1;
            end
        end else if (i_valid0) begin
            o_grant[c_REQ0] = 1'b1;
        end else if (i_valid1) begin
            o_grant[c_REQ1] = 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/gb_host_arb.sv
// ============================================================================
//  Module      : gb_host_arb
//  Description : Shares one ghostbus host port between two requesters. One
//                transaction in flight; drives gb_wen/gb_rstb for one cycle,
//                captures gb_rdata READ_LATENCY cycles after the read strobe
//                and returns a one-cycle response pulse to the owner.
//                Build option GB_ARB_FIXED_PRIO_EN (see gb_rr_arb2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_host_arb
    import gb_host_arb_pkg::*;
#(
    parameter int AW           = 24,
    parameter int DW           = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    // requester 0
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_rsp_valid,
    output logic [DW-1:0] r0_rsp_rdata,
    // requester 1
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_rsp_valid,
    output logic [DW-1:0] r1_rsp_rdata,
    // ghostbus host port
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata
);

    // WAIT lasts READ_LATENCY cycles: the counter is loaded with
    // READ_LATENCY-1 in STROBE and WAIT exits when it reaches zero, so the
    // capture edge is the READ_LATENCY-th edge after the strobe cycle ends.
    localparam logic [c_LAT_CNT_W-1:0] c_WAIT_INIT = c_LAT_CNT_W'(READ_LATENCY - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_LAT_CNT_W-1:0] r_wait_cnt;

    logic                   r_last;
    logic                   r_owner;
    logic                   r_we;
    logic [AW-1:0]          r_addr;
    logic [DW-1:0]          r_wdata;
    logic                   r_wen;
    logic                   r_rstb;
    logic                   r_rsp_valid0;
    logic                   r_rsp_valid1;
    logic [DW-1:0]          r_rsp_rdata0;
    logic [DW-1:0]          r_rsp_rdata1;

    logic [1:0]             w_grant;
    logic                   w_idle;
    logic                   w_accept;
    logic                   w_sel;
    logic                   w_sel_we;
    logic [AW-1:0]          w_sel_addr;
    logic [DW-1:0]          w_sel_wdata;
    logic                   w_to_resp;

    gb_rr_arb2 u_arb (
        .i_valid0 (r0_valid),
        .i_valid1 (r1_valid),
        .i_last   (r_last),
        .o_grant  (w_grant)
    );

    assign w_idle      = (r_state == ST_IDLE) && !gb_rst;
    assign w_accept    = w_idle && (w_grant != 2'b00);
    assign w_sel       = w_grant[c_REQ1];
    assign w_sel_we    = w_sel ? r1_we    : r0_we;
    assign w_sel_addr  = w_sel ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_sel ? r1_wdata : r0_wdata;

    // Transaction completes: write leaves STROBE, read finishes WAIT
    assign w_to_resp = ((r_state == ST_STROBE) && r_we) ||
                       ((r_state == ST_WAIT) && (r_wait_cnt == '0));

    assign r0_ready = w_idle && w_grant[c_REQ0];
    assign r1_ready = w_idle && w_grant[c_REQ1];

    // Outputs are forced low while reset is asserted, whatever the state
    assign gb_addr      = gb_rst ? '0 : r_addr;
    assign gb_wdata     = gb_rst ? '0 : r_wdata;
    assign gb_wen       = r_wen  && !gb_rst;
    assign gb_rstb      = r_rstb && !gb_rst;
    assign r0_rsp_valid = r_rsp_valid0 && !gb_rst;
    assign r1_rsp_valid = r_rsp_valid1 && !gb_rst;
    assign r0_rsp_rdata = gb_rst ? '0 : r_rsp_rdata0;
    assign r1_rsp_rdata = gb_rst ? '0 : r_rsp_rdata1;

    // State register
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_STROBE;
            ST_STROBE: w_state_nxt = r_we ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (r_wait_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Read-latency countdown
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_STROBE) begin
            r_wait_cnt <= c_WAIT_INIT;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Request latch, round-robin pointer and one-cycle bus strobes
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_rstb  <= 1'b0;
        end else begin
            r_wen  <= 1'b0;
            r_rstb <= 1'b0;
            if (w_accept) begin
                r_last  <= w_sel;
                r_owner <= w_sel;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_wen   <= w_sel_we;
                r_rstb  <= !w_sel_we;
            end
        end
    end

    // Response pulse and read-data capture for the owner
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_rdata0 <= '0;
            r_rsp_rdata1 <= '0;
        end else begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            if (w_to_resp) begin
                if (r_owner) begin
                    r_rsp_valid1 <= 1'b1;
                    r_rsp_rdata1 <= r_we ? '0 : gb_rdata;
                end else begin
                    r_rsp_valid0 <= 1'b1;
                    r_rsp_rdata0 <= r_we ? '0 : gb_rdata;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gb_host_arb.sv
// ============================================================================
//  Module      : tb_gb_host_arb
//  Description : Self-checking bench for gb_host_arb with a bus memory model,
//                a reference arbitration model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gb_host_arb;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_valid = 1'b0, r0_we = 1'b0, r0_ready, r0_rsp_valid;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r0_rsp_rdata;
    logic          r1_valid = 1'b0, r1_we = 1'b0, r1_ready, r1_rsp_valid;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0, r1_rsp_rdata;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata, gb_rdata;
    logic          gb_wen, gb_rstb;

    gb_host_arb #(.AW(AW), .DW(DW), .READ_LATENCY(RL)) u_dut (
        .gb_clk(clk), .gb_rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb),
        .gb_rdata(gb_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } stb_t;
    typedef struct { int cyc; int port; logic [DW-1:0] data; } rsp_t;

    req_t          req_q0[$];
    req_t          req_q1[$];
    stb_t          stb_q[$];
    rsp_t          rsp_q[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] bus_mem [int];
    logic [DW-1:0] rd_pipe [RL+1];

    int   cyc = 0, errors = 0, checks = 0;
    int   m_last = 1, m_idle = 0, n_acc = 0;
    logic acc_seen0 = 1'b0, acc_seen1 = 1'b0, gap_en = 1'b0, pulse1 = 1'b0, pulse_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arbitration rule: single valid wins; on contention the one that did not go last
    function automatic logic [1:0] mgrant(input logic v0, input logic v1, input int last);
        if (v0 && v1) begin
`ifdef GB_ARB_FIXED_PRIO_EN
            return 2'b01;
`else
            return (last == 0) ? 2'b10 : 2'b01;
`endif
        end
        return {v1, v0};
    endfunction

    // Bus model: memory written on gb_wen, read data appears RL cycles after the strobe
    assign gb_rdata = rd_pipe[RL];
    initial begin
        for (int i = 0; i <= RL; i++) rd_pipe[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = RL; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
            if (gb_wen) bus_mem[int'(gb_addr)] = gb_wdata;
            if (gb_rstb) rd_pipe[0] = bus_mem.exists(int'(gb_addr)) ? bus_mem[int'(gb_addr)] : '0;
            else         rd_pipe[0] = $urandom;
        end
    end

    // Reference model, grant checker and scoreboard monitor
    always @(negedge clk) begin : mon
        logic [1:0]    exp_g;
        logic [1:0]    act_r;
        int            p;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        stb_t          s;
        rsp_t          r;
        if (rst) begin
            chk("reset_outputs", {gb_wen, gb_rstb, r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready,
                                  |gb_addr, |gb_wdata, |r0_rsp_rdata, |r1_rsp_rdata}, 64'd0);
            stb_q.delete();
            rsp_q.delete();
            m_last = 1;
            m_idle = cyc + 1;
        end else begin
            exp_g = (cyc >= m_idle) ? mgrant(r0_valid, r1_valid, m_last) : 2'b00;
            chk("grant", {r1_ready, r0_ready}, exp_g);
            if (r0_valid && r0_ready) acc_seen0 = 1'b1;
            if (r1_valid && r1_ready) acc_seen1 = 1'b1;
            if (exp_g != 2'b00) begin
                p     = exp_g[1] ? 1 : 0;
                we    = p ? r1_we    : r0_we;
                addr  = p ? r1_addr  : r0_addr;
                wdata = p ? r1_wdata : r0_wdata;
                stb_q.push_back('{cyc + 1, we, addr, wdata});
                if (we) begin
                    ref_mem[int'(addr)] = wdata;
                    rsp_q.push_back('{cyc + 2, p, '0});
                    m_idle = cyc + 3;
                end else begin
                    rsp_q.push_back('{cyc + 2 + RL, p,
                                      ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0});
                    m_idle = cyc + 3 + RL;
                end
                m_last = p;
                n_acc++;
            end
            // bus strobes
            if (gb_wen || gb_rstb) begin
                if (stb_q.size() > 0 && stb_q[0].cyc == cyc) begin
                    s = stb_q.pop_front();
                    chk("strobe_type", {gb_wen, gb_rstb}, s.we ? 2'b10 : 2'b01);
                    chk("gb_addr", gb_addr, s.addr);
                    if (s.we) chk("gb_wdata", gb_wdata, s.wdata);
                end else begin
                    chk("unexpected_strobe", {gb_wen, gb_rstb}, 2'b00);
                end
            end else if (stb_q.size() > 0 && stb_q[0].cyc <= cyc) begin
                s = stb_q.pop_front();
                chk("missing_strobe", {gb_wen, gb_rstb}, s.we ? 2'b10 : 2'b01);
            end
            // responses
            act_r = {r1_rsp_valid, r0_rsp_valid};
            if (act_r != 2'b00) begin
                if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                    r = rsp_q.pop_front();
                    chk("rsp_port", act_r, (r.port == 1) ? 2'b10 : 2'b01);
                    chk("rsp_rdata", (r.port == 1) ? r1_rsp_rdata : r0_rsp_rdata, r.data);
                end else begin
                    chk("unexpected_rsp", act_r, 2'b00);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                r = rsp_q.pop_front();
                chk("missing_rsp", act_r, (r.port == 1) ? 2'b10 : 2'b01);
            end
        end
    end

    // Requester drivers: hold each request until accepted, optional random gaps
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc_seen0) begin
                acc_seen0 = 1'b0;
                if (req_q0.size() > 0) req_q0.delete(0);
                r0_valid = 1'b0;
            end
            if (acc_seen1) begin
                acc_seen1 = 1'b0;
                if (req_q1.size() > 0 && !pulse_on) req_q1.delete(0);
                r1_valid = 1'b0;
            end
            if (!r0_valid && req_q0.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                r0_valid = 1'b1;
                r0_we    = req_q0[0].we;
                r0_addr  = req_q0[0].addr;
                r0_wdata = req_q0[0].wdata;
            end
            if (pulse1) begin
                pulse1   = 1'b0;
                pulse_on = 1'b1;
                r1_valid = 1'b1;
                r1_we    = 1'b1;
                r1_addr  = 24'hABCDEF;
                r1_wdata = 32'h5A5A5A5A;
            end else if (pulse_on) begin
                pulse_on = 1'b0;
                r1_valid = 1'b0;
            end else if (!r1_valid && req_q1.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                r1_valid = 1'b1;
                r1_we    = req_q1[0].we;
                r1_addr  = req_q1[0].addr;
                r1_wdata = req_q1[0].wdata;
            end
        end
    end

    task automatic push0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_q0.push_back('{we, a, d});
    endtask

    task automatic push1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_q1.push_back('{we, a, d});
    endtask

    task automatic wait_done(input int budget);
        int t;
        int pending;
        t = 0;
        pending = 1;
        while (pending != 0 && t < budget) begin
            @(negedge clk);
            t++;
            pending = req_q0.size() + req_q1.size() + stb_q.size() + rsp_q.size()
                    + ((cyc < m_idle) ? 1 : 0) + (r0_valid ? 1 : 0) + (r1_valid ? 1 : 0);
        end
        chk("drain_pending", pending, 0);
    endtask

    task automatic wait_accept(input int budget);
        int k;
        int t;
        k = n_acc;
        t = 0;
        while (n_acc == k && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("accept_seen", (n_acc != k) ? 1 : 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // write then read back on requester 0
        push0(1'b1, 24'h000010, 32'hDEADBEEF);
        push0(1'b0, 24'h000010, 32'h0);
        wait_done(200);

        // contention, both requesters hold valid
        for (int i = 0; i < 4; i++) begin
            push0(1'b1, 24'h000100 + 24'(i), $urandom);
            push1(1'b1, 24'h000200 + 24'(i), $urandom);
        end
        wait_done(200);

        // r1 raises valid for one cycle while r0 owns the bus
        push0(1'b0, 24'h000010, 32'h0);
        wait_accept(100);
        pulse1 = 1'b1;
        wait_done(200);

        // reset during the WAIT phase of a read, then an r1 transaction
        push0(1'b0, 24'h000100, 32'h0);
        wait_accept(100);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push1(1'b1, 24'h000300, 32'h13572468);
        push1(1'b0, 24'h000300, 32'h0);
        wait_done(200);

        // randomized mixed traffic on a small address window
        gap_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push0(1'($urandom_range(0, 1)), 24'h000040 + 24'($urandom_range(0, 7) * 4), $urandom);
            push1(1'($urandom_range(0, 1)), 24'h000040 + 24'($urandom_range(0, 7) * 4), $urandom);
        end
        wait_done(4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
